// File: rtl/riscv_tag_policy_ctrl_pkg.sv
// Package: riscv_tag_policy_ctrl_pkg
// Shared definitions for the DIFT policy commit controller and the
// downstream tag decode logic:
//   - tag_pol_state_e : commit FSM states (IDLE -> DRAIN -> COMMIT)
//   - CSR_TPR/CSR_TCR : CSR addresses of the two policy registers
//   - TPR_* constants : bit positions of the TPR fields
//   - tp_any_write    : helper that flags a write to either policy CSR
package riscv_tag_policy_ctrl_pkg;

  typedef enum logic [1:0] {
    TP_IDLE   = 2'd0,
    TP_DRAIN  = 2'd1,
    TP_COMMIT = 2'd2
  } tag_pol_state_e;

  // Custom user read/write CSR space.
  localparam logic [11:0] CSR_TPR = 12'h8F0;
  localparam logic [11:0] CSR_TCR = 12'h8F1;

  // TPR field layout: two-bit propagation modes per instruction class,
  // followed by the load/store enable fields.
  localparam int unsigned TPR_ALU_MODE_LO       = 0;
  localparam int unsigned TPR_ALU_MODE_HI       = 1;
  localparam int unsigned TPR_SHIFT_MODE_LO     = 2;
  localparam int unsigned TPR_SHIFT_MODE_HI     = 3;
  localparam int unsigned TPR_CMP_MODE_LO       = 4;
  localparam int unsigned TPR_CMP_MODE_HI       = 5;
  localparam int unsigned TPR_CSR_MODE_LO       = 6;
  localparam int unsigned TPR_CSR_MODE_HI       = 7;
  localparam int unsigned LOADSTORE_EN_LOW      = 8;
  localparam int unsigned LOADSTORE_EN_HIGH     = 9;
  localparam int unsigned LOADSTORE_EN_BYTE     = 10;
  localparam int unsigned LOADSTORE_EN_HALF     = 11;
  localparam int unsigned LOADSTORE_EN_WORD     = 12;

  function automatic logic tp_any_write(input logic tpr_we, input logic tcr_we);
    return tpr_we | tcr_we;
  endfunction

endpackage

// File: rtl/riscv_tag_inflight_cnt.sv
// Module: riscv_tag_inflight_cnt
// Saturating up/down counter of instructions between ID issue and WB retire.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   inc_i         : instruction issued this cycle
//   dec_i         : instruction retired this cycle
//   cnt_o         : current in-flight count
//   cnt_next_o    : count that will hold next cycle
//   err_o         : one-cycle flag, increment at MAX or decrement at zero
module riscv_tag_inflight_cnt #(
  parameter int unsigned MAX = 3,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         err_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         err_s;

  // Next count; simultaneous issue and retire cancel out, out-of-range steps hold.
  always_comb begin
    cnt_d = cnt_q;
    err_s = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX_C) begin
        err_s = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) begin
        err_s = 1'b1;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
  assign err_o      = err_s;

endmodule

// File: rtl/riscv_tag_policy_ctrl.sv
// Module: riscv_tag_policy_ctrl
// Commit controller for the DIFT policy CSRs (TPR, TCR). CSR writes land in
// shadow registers; the controller stalls ID, waits for in-flight
// instructions to drain, then updates both committed registers together so
// no instruction runs under a mixed old/new policy.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   csr_tpr_we_i / csr_tpr_wdata_i  : TPR write strobe and data
//   csr_tcr_we_i / csr_tcr_wdata_i  : TCR write strobe and data
//   issue_valid_i / retire_valid_i  : ID->EX issue and WB retire strobes
//   tpr_o / tcr_o                   : committed policy values
//   stall_id_o                      : hold ID while an update is in progress
//   busy_o                          : update pending
//   commit_o                        : one-cycle pulse, new policy from next cycle
//   timeout_err_o                   : sticky drain timeout / counter error
module riscv_tag_policy_ctrl
  import riscv_tag_policy_ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT  = 3,
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter logic [31:0] TPR_RESET     = 32'h0000_0000,
  parameter logic [31:0] TCR_RESET     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_tpr_we_i,
  input  logic [31:0] csr_tpr_wdata_i,
  input  logic        csr_tcr_we_i,
  input  logic [31:0] csr_tcr_wdata_i,
  input  logic        issue_valid_i,
  input  logic        retire_valid_i,
  output logic [31:0] tpr_o,
  output logic [31:0] tcr_o,
  output logic        stall_id_o,
  output logic        busy_o,
  output logic        commit_o,
  output logic        timeout_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  // One spare bit keeps DRAIN_TIMEOUT-1 representable for any parameter value.
  localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

  tag_pol_state_e state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0] shadow_tpr_q, shadow_tpr_d;
  logic [31:0] shadow_tcr_q, shadow_tcr_d;
  logic [31:0] tpr_q, tpr_d;
  logic [31:0] tcr_q, tcr_d;
  logic        err_q, err_d;
  logic        stall_q, commit_q;

  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             cnt_err_s;
  logic             any_we_s;
  logic             force_s;

  riscv_tag_inflight_cnt #(
    .MAX (MAX_INFLIGHT),
    .W   (CNT_W)
  ) u_inflight_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (issue_valid_i),
    .dec_i      (retire_valid_i),
    .cnt_o      (cnt_s),
    .cnt_next_o (cnt_next_s),
    .err_o      (cnt_err_s)
  );

  assign any_we_s = tp_any_write(csr_tpr_we_i, csr_tcr_we_i);

  // Policy update FSM and drain timeout counter.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    force_s = 1'b0;
    case (state_q)
      TP_IDLE: begin
        tmo_d = '0;
        if (any_we_s) begin
          state_d = TP_DRAIN;
        end else begin
          state_d = TP_IDLE;
        end
      end
      TP_DRAIN: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Looking at next-cycle count lets a retire in this cycle finish the drain.
        if (cnt_next_s == '0) begin
          state_d = TP_COMMIT;
        end else if (tmo_q == TMO_LAST) begin
          state_d = TP_COMMIT;
          force_s = 1'b1;
        end else begin
          state_d = TP_DRAIN;
        end
      end
      TP_COMMIT: begin
        tmo_d = '0;
        // A write landing on the commit cycle needs its own drain.
        if (any_we_s) begin
          state_d = TP_DRAIN;
        end else begin
          state_d = TP_IDLE;
        end
      end
      default: begin
        state_d = TP_IDLE;
        tmo_d   = '0;
      end
    endcase
  end

  // Shadow capture, committed-value update and sticky error.
  always_comb begin
    shadow_tpr_d = csr_tpr_we_i ? csr_tpr_wdata_i : shadow_tpr_q;
    shadow_tcr_d = csr_tcr_we_i ? csr_tcr_wdata_i : shadow_tcr_q;
    // The commit reads the shadow before any same-cycle write lands in it.
    if (state_q == TP_COMMIT) begin
      tpr_d = shadow_tpr_q;
      tcr_d = shadow_tcr_q;
    end else begin
      tpr_d = tpr_q;
      tcr_d = tcr_q;
    end
    err_d = err_q | force_s | cnt_err_s;
  end

  // State, data and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TP_IDLE;
      tmo_q        <= '0;
      shadow_tpr_q <= TPR_RESET;
      shadow_tcr_q <= TCR_RESET;
      tpr_q        <= TPR_RESET;
      tcr_q        <= TCR_RESET;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      shadow_tpr_q <= shadow_tpr_d;
      shadow_tcr_q <= shadow_tcr_d;
      tpr_q        <= tpr_d;
      tcr_q        <= tcr_d;
      err_q        <= err_d;
      stall_q      <= (state_d != TP_IDLE);
      commit_q     <= (state_d == TP_COMMIT);
    end
  end

  assign tpr_o         = tpr_q;
  assign tcr_o         = tcr_q;
  assign stall_id_o    = stall_q;
  assign busy_o        = stall_q;
  assign commit_o      = commit_q;
  assign timeout_err_o = err_q;

endmodule

// File: tb/tb_riscv_tag_policy_ctrl.sv
module tb_riscv_tag_policy_ctrl;

  logic        clk;
  logic        rst_n;
  logic        csr_tpr_we_i;
  logic [31:0] csr_tpr_wdata_i;
  logic        csr_tcr_we_i;
  logic [31:0] csr_tcr_wdata_i;
  logic        issue_valid_i;
  logic        retire_valid_i;
  logic [31:0] tpr_o;
  logic [31:0] tcr_o;
  logic        stall_id_o;
  logic        busy_o;
  logic        commit_o;
  logic        timeout_err_o;

  int n_vec = 0;
  int n_err = 0;
  // Expected committed policy {tcr, tpr}, pushed when the write is driven.
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  riscv_tag_policy_ctrl #(
    .MAX_INFLIGHT  (3),
    .DRAIN_TIMEOUT (64),
    .TPR_RESET     (32'h0000_0000),
    .TCR_RESET     (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_tpr_we_i    (csr_tpr_we_i),
    .csr_tpr_wdata_i (csr_tpr_wdata_i),
    .csr_tcr_we_i    (csr_tcr_we_i),
    .csr_tcr_wdata_i (csr_tcr_wdata_i),
    .issue_valid_i   (issue_valid_i),
    .retire_valid_i  (retire_valid_i),
    .tpr_o           (tpr_o),
    .tcr_o           (tcr_o),
    .stall_id_o      (stall_id_o),
    .busy_o          (busy_o),
    .commit_o        (commit_o),
    .timeout_err_o   (timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    csr_tpr_we_i = 1'b0; csr_tpr_wdata_i = 32'h0;
    csr_tcr_we_i = 1'b0; csr_tcr_wdata_i = 32'h0;
    issue_valid_i = 1'b0; retire_valid_i = 1'b0;
    step(); step();
    n_vec++; if (tpr_o !== 32'h0) begin n_err++; $display("FAIL reset_tpr got=%h exp=%h", tpr_o, 32'h0); end
    n_vec++; if (tcr_o !== 32'h0) begin n_err++; $display("FAIL reset_tcr got=%h exp=%h", tcr_o, 32'h0); end
    n_vec++; if ({stall_id_o, busy_o, commit_o, timeout_err_o} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got=%b exp=%b", {stall_id_o, busy_o, commit_o, timeout_err_o}, 4'b0000);
    end
    rst_n = 1'b1;
    step();
    exp_q.delete();
  endtask

  task automatic test_idle_write();
    exp_q.push_back({32'h0, 32'h0000_00F0});
    csr_tpr_we_i = 1'b1; csr_tpr_wdata_i = 32'h0000_00F0;
    step();
    csr_tpr_we_i = 1'b0;
    n_vec++; if ({stall_id_o, commit_o} !== 2'b10) begin n_err++; $display("FAIL idle_t1 got=%b exp=%b", {stall_id_o, commit_o}, 2'b10); end
    step();
    n_vec++; if ({stall_id_o, commit_o} !== 2'b11) begin n_err++; $display("FAIL idle_t2 got=%b exp=%b", {stall_id_o, commit_o}, 2'b11); end
    n_vec++; if (tpr_o !== 32'h0) begin n_err++; $display("FAIL idle_tpr_t2 got=%h exp=%h", tpr_o, 32'h0); end
    step();
    n_vec++; if ({stall_id_o, busy_o, commit_o} !== 3'b000) begin n_err++; $display("FAIL idle_t3 got=%b exp=%b", {stall_id_o, busy_o, commit_o}, 3'b000); end
    exp_v = exp_q.pop_front();
    n_vec++; if ({tcr_o, tpr_o} !== exp_v) begin n_err++; $display("FAIL idle_commit got=%h exp=%h", {tcr_o, tpr_o}, exp_v); end
  endtask

  task automatic test_drain_retire();
    issue_valid_i = 1'b1;
    repeat (3) step();
    issue_valid_i = 1'b0;
    exp_q.push_back({32'h5, 32'h0000_00F0});
    csr_tcr_we_i = 1'b1; csr_tcr_wdata_i = 32'h5;
    step();
    csr_tcr_we_i = 1'b0;
    retire_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({busy_o, commit_o} !== 2'b10) begin n_err++; $display("FAIL drain_hold_%0d got=%b exp=%b", i, {busy_o, commit_o}, 2'b10); end
      step();
    end
    retire_valid_i = 1'b0;
    n_vec++; if (commit_o !== 1'b1) begin n_err++; $display("FAIL drain_commit got=%b exp=%b", commit_o, 1'b1); end
    step();
    exp_v = exp_q.pop_front();
    n_vec++; if ({tcr_o, tpr_o} !== exp_v) begin n_err++; $display("FAIL drain_value got=%h exp=%h", {tcr_o, tpr_o}, exp_v); end
    n_vec++; if (stall_id_o !== 1'b0) begin n_err++; $display("FAIL drain_stall_end got=%b exp=%b", stall_id_o, 1'b0); end
  endtask

  task automatic test_back_to_back();
    int commits;
    int saw_one;
    commits = 0; saw_one = 0;
    issue_valid_i = 1'b1;
    repeat (2) step();
    issue_valid_i = 1'b0;
    csr_tpr_we_i = 1'b1; csr_tpr_wdata_i = 32'h1;
    step();
    csr_tpr_wdata_i = 32'h2;
    step();
    csr_tpr_we_i = 1'b0;
    exp_q.push_back({32'h5, 32'h2});
    retire_valid_i = 1'b1;
    step(); step();
    retire_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (commit_o === 1'b1) commits++;
      if (tpr_o === 32'h1) saw_one++;
      step();
    end
    n_vec++; if (commits != 1) begin n_err++; $display("FAIL b2b_commits got=%0d exp=%0d", commits, 1); end
    n_vec++; if (saw_one != 0) begin n_err++; $display("FAIL b2b_tpr_seen_1 got=%0d exp=%0d", saw_one, 0); end
    exp_v = exp_q.pop_front();
    n_vec++; if ({tcr_o, tpr_o} !== exp_v) begin n_err++; $display("FAIL b2b_value got=%h exp=%h", {tcr_o, tpr_o}, exp_v); end
  endtask

  task automatic test_commit_cycle_write();
    exp_q.push_back({32'h5, 32'h7});
    csr_tpr_we_i = 1'b1; csr_tpr_wdata_i = 32'h7;
    step();
    csr_tpr_we_i = 1'b0;
    step();
    n_vec++; if (commit_o !== 1'b1) begin n_err++; $display("FAIL ccw_commit1 got=%b exp=%b", commit_o, 1'b1); end
    exp_q.push_back({32'h6, 32'h9});
    csr_tpr_we_i = 1'b1; csr_tpr_wdata_i = 32'h9;
    csr_tcr_we_i = 1'b1; csr_tcr_wdata_i = 32'h6;
    step();
    csr_tpr_we_i = 1'b0; csr_tcr_we_i = 1'b0;
    exp_v = exp_q.pop_front();
    n_vec++; if ({tcr_o, tpr_o} !== exp_v) begin n_err++; $display("FAIL ccw_value1 got=%h exp=%h", {tcr_o, tpr_o}, exp_v); end
    n_vec++; if ({stall_id_o, busy_o, commit_o} !== 3'b110) begin n_err++; $display("FAIL ccw_redrain got=%b exp=%b", {stall_id_o, busy_o, commit_o}, 3'b110); end
    step();
    n_vec++; if (commit_o !== 1'b1) begin n_err++; $display("FAIL ccw_commit2 got=%b exp=%b", commit_o, 1'b1); end
    step();
    exp_v = exp_q.pop_front();
    n_vec++; if ({tcr_o, tpr_o} !== exp_v) begin n_err++; $display("FAIL ccw_value2 got=%h exp=%h", {tcr_o, tpr_o}, exp_v); end
    n_vec++; if (stall_id_o !== 1'b0) begin n_err++; $display("FAIL ccw_stall_end got=%b exp=%b", stall_id_o, 1'b0); end
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    issue_valid_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    exp_q.push_back({32'h6, 32'hAB});
    csr_tpr_we_i = 1'b1; csr_tpr_wdata_i = 32'hAB;
    step();
    csr_tpr_we_i = 1'b0;
    // Bounded wait: first DRAIN cycle is i=1, forced commit expected at i=65.
    for (int i = 1; i <= 100; i++) begin
      if (commit_o === 1'b1) begin
        seen = i;
        break;
      end
      n_vec++; if (timeout_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_early_err cyc=%0d got=%b exp=%b", i, timeout_err_o, 1'b0); end
      step();
    end
    n_vec++; if (seen != 65) begin n_err++; $display("FAIL tmo_commit_cycle got=%0d exp=%0d", seen, 65); end
    n_vec++; if (timeout_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_err_set got=%b exp=%b", timeout_err_o, 1'b1); end
    step();
    exp_v = exp_q.pop_front();
    n_vec++; if ({tcr_o, tpr_o} !== exp_v) begin n_err++; $display("FAIL tmo_value got=%h exp=%h", {tcr_o, tpr_o}, exp_v); end
    retire_valid_i = 1'b1;
    step();
    retire_valid_i = 1'b0;
    repeat (5) step();
    n_vec++; if (timeout_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_err_sticky got=%b exp=%b", timeout_err_o, 1'b1); end
  endtask

  task automatic test_reset_mid_drain();
    int commits;
    int bad_tpr;
    commits = 0; bad_tpr = 0;
    test_reset();
    n_vec++; if (timeout_err_o !== 1'b0) begin n_err++; $display("FAIL rst_clears_err got=%b exp=%b", timeout_err_o, 1'b0); end
    issue_valid_i = 1'b1;
    step();
    issue_valid_i = 1'b0;
    csr_tpr_we_i = 1'b1; csr_tpr_wdata_i = 32'hA;
    step();
    csr_tpr_we_i = 1'b0;
    step();
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rmd_busy got=%b exp=%b", busy_o, 1'b1); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({tpr_o, stall_id_o, busy_o, commit_o} !== {32'h0, 3'b000}) begin
      n_err++; $display("FAIL rmd_async got=%h exp=%h", {tpr_o, stall_id_o, busy_o, commit_o}, {32'h0, 3'b000});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (commit_o === 1'b1 || busy_o === 1'b1) commits++;
      if (tpr_o !== 32'h0) bad_tpr++;
      step();
    end
    n_vec++; if (commits != 0) begin n_err++; $display("FAIL rmd_no_commit got=%0d exp=%0d", commits, 0); end
    n_vec++; if (bad_tpr != 0) begin n_err++; $display("FAIL rmd_tpr_reset got=%0d exp=%0d", bad_tpr, 0); end
  endtask

  task automatic test_cnt_errors();
    retire_valid_i = 1'b1;
    step();
    retire_valid_i = 1'b0;
    n_vec++; if (timeout_err_o !== 1'b1) begin n_err++; $display("FAIL underflow_err got=%b exp=%b", timeout_err_o, 1'b1); end
    test_reset();
    issue_valid_i = 1'b1;
    repeat (3) step();
    n_vec++; if (timeout_err_o !== 1'b0) begin n_err++; $display("FAIL at_max_no_err got=%b exp=%b", timeout_err_o, 1'b0); end
    step();
    issue_valid_i = 1'b0;
    n_vec++; if (timeout_err_o !== 1'b1) begin n_err++; $display("FAIL overflow_err got=%b exp=%b", timeout_err_o, 1'b1); end
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_drain_retire();
    test_back_to_back();
    test_commit_cycle_write();
    test_timeout();
    test_reset_mid_drain();
    test_cnt_errors();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
